rgb2gs_pipe: RTL

- Parametrised, pipelined RGB-to-grayscale converter with valid/ready flow control and a per-pixel selectable conversion mode.
- Sits between the pixel source (camera/frame reader) and the detection front-end (filters, thresholding).
- Generalises the fixed 8-bit single-cycle averager: configurable channel width, four conversion modes, backpressure, and a sideband passthrough.

---
 rtl/rgb2gs_pipe.sv | 119 +++++++++++
 1 files changed

// File: rtl/rgb2gs_pipe.sv
// Two-stage RGB to grayscale converter with per-pixel mode and valid/ready flow control.
// S1 registers partial products and pre-sums; S2 finishes the selected mode and drives the outputs.
module rgb2gs_pipe #(
    parameter int CW = 8,
    parameter int UW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3*CW-1:0] rgb,
    input  logic [1:0]      rgb_mode,
    input  logic [UW-1:0]   rgb_user,
    input  logic            rgb_en,
    output logic            rgb_ready,
    output logic [CW-1:0]   gs,
    output logic [UW-1:0]   gs_user,
    output logic            gs_valid,
    input  logic            gs_ready
);

    logic [CW-1:0]   w_r;
    logic [CW-1:0]   w_g;
    logic [CW-1:0]   w_b;
    logic            w_en;
    logic [CW+6:0]   w_p77;
    logic [CW+7:0]   w_p150;
    logic [CW+4:0]   w_p29;
    logic [CW:0]     w_rb;
    logic [CW-1:0]   w_mx;

    logic            r1_valid;
    logic [CW+6:0]   r1_p77;
    logic [CW+7:0]   r1_p150;
    logic [CW+4:0]   r1_p29;
    logic [CW:0]     r1_rb;
    logic [CW-1:0]   r1_mx;
    logic [CW-1:0]   r1_g;
    logic [1:0]      r1_mode;
    logic [UW-1:0]   r1_user;

    logic            r_gs_valid;
    logic [CW-1:0]   r_gs;
    logic [UW-1:0]   r_gs_user;

    logic [CW+8:0]   w_luma;
    logic [CW-1:0]   w_luma_gs;
    logic [CW-1:0]   w_half_rb;
    logic [CW:0]     w_avg;
    logic [CW-1:0]   w_avg_gs;
    logic [CW-1:0]   w_val_gs;
    logic [CW-1:0]   w_gs_next;

    assign w_r = rgb[3*CW-1:2*CW];
    assign w_g = rgb[2*CW-1:CW];
    assign w_b = rgb[CW-1:0];

    // A single stall signal freezes both stages while the output is blocked.
    assign w_en      = !r_gs_valid || gs_ready;
    assign rgb_ready = w_en;

    assign w_p77  = (CW+7)'(w_r) * (CW+7)'(77);
    assign w_p150 = (CW+8)'(w_g) * (CW+8)'(150);
    assign w_p29  = (CW+5)'(w_b) * (CW+5)'(29);
    assign w_rb   = (CW+1)'(w_r) + (CW+1)'(w_b);
    assign w_mx   = (w_r > w_b) ? w_r : w_b;

    // Weights sum to 256, so the rounded luma never exceeds 2^CW-1.
    assign w_luma = (CW+9)'(r1_p77) + (CW+9)'(r1_p150)
                  + (CW+9)'(r1_p29) + (CW+9)'(128);
    assign w_luma_gs = CW'(w_luma >> 8);
    assign w_half_rb = CW'(r1_rb >> 1);
    assign w_avg     = (CW+1)'(w_half_rb) + (CW+1)'(r1_g);
    assign w_avg_gs  = CW'(w_avg >> 1);
    assign w_val_gs  = (r1_mx > r1_g) ? r1_mx : r1_g;

    always_comb begin
        w_gs_next = r1_g;
        unique case (r1_mode)
            2'd0:    w_gs_next = w_avg_gs;
            2'd1:    w_gs_next = w_luma_gs;
            2'd2:    w_gs_next = w_val_gs;
            default: w_gs_next = r1_g;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_valid   <= 1'b0;
            r1_p77     <= '0;
            r1_p150    <= '0;
            r1_p29     <= '0;
            r1_rb      <= '0;
            r1_mx      <= '0;
            r1_g       <= '0;
            r1_mode    <= '0;
            r1_user    <= '0;
            r_gs_valid <= 1'b0;
            r_gs       <= '0;
            r_gs_user  <= '0;
        end else if (w_en) begin
            r1_valid   <= rgb_en;
            r1_p77     <= w_p77;
            r1_p150    <= w_p150;
            r1_p29     <= w_p29;
            r1_rb      <= w_rb;
            r1_mx      <= w_mx;
            r1_g       <= w_g;
            r1_mode    <= rgb_mode;
            r1_user    <= rgb_user;
            r_gs_valid <= r1_valid;
            r_gs       <= w_gs_next;
            r_gs_user  <= r1_user;
        end
    end

    assign gs       = r_gs;
    assign gs_user  = r_gs_user;
    assign gs_valid = r_gs_valid;

endmodule
